updown_counter: RTL and testbench

Parametrised up/down counter with programmable step, terminal limit, wrap or saturate overflow handling, and a one-shot mode. It supersedes the fixed increment-by-one counter in the timer and peripheral datapaths. It keeps that counter's clear/load/enable priority and adds direction, step, limit and terminal-count signalling. The count, terminal-count pulse and done flag are all registered.

---
 rtl/updown_counter.sv | 97 +++++++++
 tb/tb_updown_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Up/down counter with programmable step, terminal limit, wrap or
// saturate boundary handling and a one-shot mode.
// The count, terminal-count pulse and done flag are all registered.
// Update priority on each edge: reset (active-low) > clear > load > enable > hold.
module updown_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             sat_i,
    input  logic             os_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0] lim_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             tc_o,
    output logic             done_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             tc_reg, tc_next;

    // One extra bit on the up sum so a carry past the top of the range
    // still registers as a hit instead of silently wrapping.
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] dn_diff;
    logic             up_hit;
    logic             dn_hit;
    logic             hit;

    // Boundary detection for both directions; only one is used per cycle.
    always_comb begin
        up_sum  = {1'b0, cnt_reg} + {1'b0, step_i};
        dn_diff = cnt_reg - step_i;
        up_hit  = (up_sum > {1'b0, lim_i});
        dn_hit  = (step_i > cnt_reg);
        hit     = dir_i ? dn_hit : up_hit;
    end

    // Next count, terminal-count pulse and one-shot state.
    always_comb begin
        cnt_next   = cnt_reg;
        tc_next    = 1'b0;
        state_next = state_reg;

        if (clr_i) begin
            cnt_next   = '0;
            state_next = ST_RUN;
        end else if (we_i) begin
            cnt_next   = dat_i;
            state_next = ST_RUN;
        end else if (en_i && (state_reg == ST_RUN)) begin
            if (hit) begin
                tc_next = 1'b1;
                // Wrap reloads the opposite end; saturate clamps at the near end.
                if (dir_i) begin
                    cnt_next = sat_i ? '0 : lim_i;
                end else begin
                    cnt_next = sat_i ? lim_i : '0;
                end
                if (os_i) begin
                    state_next = ST_DONE;
                end
            end else begin
                cnt_next = dir_i ? dn_diff : up_sum[WIDTH-1:0];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_reg   <= '0;
            tc_reg    <= 1'b0;
            state_reg <= ST_RUN;
        end else begin
            cnt_reg   <= cnt_next;
            tc_reg    <= tc_next;
            state_reg <= state_next;
        end
    end

    assign dat_o  = cnt_reg;
    assign tc_o   = tc_reg;
    assign done_o = (state_reg == ST_DONE);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter with hand-computed expectations.
module tb_updown_counter;

    localparam int WIDTH = 8;

    logic             clk_i;
    logic             rst_i;
    logic             clr_i;
    logic             we_i;
    logic             en_i;
    logic             dir_i;
    logic             sat_i;
    logic             os_i;
    logic [WIDTH-1:0] step_i;
    logic [WIDTH-1:0] lim_i;
    logic [WIDTH-1:0] dat_i;
    logic [WIDTH-1:0] dat_o;
    logic             tc_o;
    logic             done_o;

    int total;
    int bad;

    updown_counter #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .we_i   (we_i),
        .en_i   (en_i),
        .dir_i  (dir_i),
        .sat_i  (sat_i),
        .os_i   (os_i),
        .step_i (step_i),
        .lim_i  (lim_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .tc_o   (tc_o),
        .done_o (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Check all three outputs in one go.
    task automatic expect3(input string tag, input int d, input int t, input int dn);
        check({tag, ".dat"},  32'(dat_o),  32'(d));
        check({tag, ".tc"},   32'(tc_o),   32'(t));
        check({tag, ".done"}, 32'(done_o), 32'(dn));
    endtask

    initial begin
        int tc_count;
        total = 0;
        bad   = 0;
        rst_i = 1'b0; clr_i = 1'b0; we_i = 1'b0; en_i = 1'b0;
        dir_i = 1'b0; sat_i = 1'b0; os_i = 1'b0;
        step_i = '0; lim_i = '0; dat_i = '0;
        #2;

        // Reset dominates clear/load/enable
        clr_i = 1'b1; we_i = 1'b1; en_i = 1'b1; dat_i = 8'h55; step_i = 8'd1; lim_i = 8'd9;
        tick();
        expect3("reset", 0, 0, 0);
        rst_i = 1'b1; clr_i = 1'b0; we_i = 1'b0; en_i = 1'b0;

        // Up wrap with lim 9, step 1
        dir_i = 1'b0; sat_i = 1'b0; os_i = 1'b0; step_i = 8'd1; lim_i = 8'd9; en_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("upwrap.dat", 32'(dat_o), 32'(i));
            check("upwrap.tc",  32'(tc_o),  32'd0);
        end
        tick();
        check("upwrap.wrapdat", 32'(dat_o), 32'd0);
        check("upwrap.wraptc",  32'(tc_o),  32'd1);
        tc_count = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tc_o) tc_count++;
        end
        check("upwrap.period_tc", 32'(tc_o), 32'd1);
        check("upwrap.tc_count",  32'(tc_count), 32'd1);

        // Down saturate from 10 by 3
        en_i = 1'b0; we_i = 1'b1; dat_i = 8'd10;
        tick();
        expect3("dsat.load", 10, 0, 0);
        we_i = 1'b0; en_i = 1'b1; dir_i = 1'b1; sat_i = 1'b1; step_i = 8'd3;
        tick(); expect3("dsat.s1", 7, 0, 0);
        tick(); expect3("dsat.s2", 4, 0, 0);
        tick(); expect3("dsat.s3", 1, 0, 0);
        tick(); expect3("dsat.hit", 0, 1, 0);
        tick(); expect3("dsat.hold1", 0, 1, 0);
        tick(); expect3("dsat.hold2", 0, 1, 0);
        en_i = 1'b0;
        tick(); expect3("dsat.idle", 0, 0, 0);

        // Up saturate clamps to lim
        we_i = 1'b1; dat_i = 8'd98;
        tick();
        we_i = 1'b0; en_i = 1'b1; dir_i = 1'b0; sat_i = 1'b1; lim_i = 8'd100; step_i = 8'd5;
        tick(); expect3("usat.hit", 100, 1, 0);
        tick(); expect3("usat.hold", 100, 1, 0);

        // One-shot up, lim 6, step 2
        en_i = 1'b0; clr_i = 1'b1;
        tick(); expect3("os.clr", 0, 0, 0);
        clr_i = 1'b0; os_i = 1'b1; dir_i = 1'b0; sat_i = 1'b0; lim_i = 8'd6; step_i = 8'd2; en_i = 1'b1;
        tick(); expect3("os.s1", 2, 0, 0);
        tick(); expect3("os.s2", 4, 0, 0);
        tick(); expect3("os.s3", 6, 0, 0);
        tick(); expect3("os.hit", 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect3("os.held", 0, 0, 1);
        end
        we_i = 1'b1; dat_i = 8'd5;
        tick(); expect3("os.load", 5, 0, 0);
        we_i = 1'b0; step_i = 8'd1;
        tick(); expect3("os.resume", 6, 0, 0);
        tick(); expect3("os.hit2", 0, 1, 1);

        // Reset while in DONE returns to RUN
        rst_i = 1'b0; clr_i = 1'b1; we_i = 1'b1; en_i = 1'b1;
        tick(); expect3("rst.done", 0, 0, 0);
        rst_i = 1'b1; clr_i = 1'b0; we_i = 1'b0; os_i = 1'b0;
        tick(); expect3("rst.run", 1, 0, 0);

        // Priority: clear over load over enable
        clr_i = 1'b1; we_i = 1'b1; en_i = 1'b1; dat_i = 8'h55;
        tick(); expect3("prio.clr", 0, 0, 0);
        clr_i = 1'b0;
        tick(); expect3("prio.load", 8'h55, 0, 0);
        we_i = 1'b0; en_i = 1'b0;

        // Out-of-range load with zero step is an up hit
        we_i = 1'b1; dat_i = 8'd200;
        tick(); expect3("oor.load", 200, 0, 0);
        we_i = 1'b0; en_i = 1'b1; lim_i = 8'd100; dir_i = 1'b0; sat_i = 1'b0; step_i = 8'd0;
        tick(); expect3("oor.hit", 0, 1, 0);

        // Zero step down holds without a hit
        en_i = 1'b0; we_i = 1'b1; dat_i = 8'd50;
        tick();
        we_i = 1'b0; en_i = 1'b1; dir_i = 1'b1;
        tick(); expect3("z.down1", 50, 0, 0);
        tick(); expect3("z.down2", 50, 0, 0);

        // lim 0: every up step hits
        dir_i = 1'b0; lim_i = 8'd0; step_i = 8'd1; clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick(); expect3("lim0.a", 0, 1, 0);
        tick(); expect3("lim0.b", 0, 1, 0);

        // Down wrap reloads lim
        dir_i = 1'b1; sat_i = 1'b0; lim_i = 8'd20; step_i = 8'd3; en_i = 1'b0; we_i = 1'b1; dat_i = 8'd2;
        tick();
        we_i = 1'b0; en_i = 1'b1;
        tick(); expect3("dwrap", 20, 1, 0);
        tick(); expect3("dwrap.next", 17, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
